branch_predict_resolve: RTL
===========================

// Module: branch_predict_resolve
// PURPOSE
//  Execute-stage branch unit and fetch-side predictor in one block.
//  - Resolves a 4-bit branch condition against ALU flags, including signed and unsigned compares.
//  - Fetch reads a direct-mapped table of 2-bit saturating counters to predict taken/not-taken.
//  - Execute compares the resolved outcome with the prediction carried down the pipe, raises
//    mispredict, and trains the table. Saturating statistics counters are kept for perf tuning.
// PARAMETERS
//  PC_W      16  width of fetch/execute PC
//  BHT_DEPTH 16  counter table entries; power of 2, >=2; index = pc[IDX_W:1] (halfword-aligned PC)
//  STAT_W    16  width of branch/mispredict statistics counters
// PORTS
//  clk            in   1       clock, rising edge
//  rst_n          in   1       asynchronous active-low reset
//  f_pc           in   PC_W    fetch PC for the lookup
//  f_pred_taken   out  1       prediction for f_pc (combinational)
//  ex_valid       in   1       execute holds a real instruction this cycle
//  ex_stall       in   1       execute frozen; blocks all state updates
//  ex_pc          in   PC_W    PC of the instruction in execute
//  ex_branch      in   4       condition code (see BEHAVIOUR)
//  ex_pred_taken  in   1       prediction made at fetch for this instruction
//  ZF,CF,SF,OF    in   1 each  ALU flags; CF=1 means borrow on subtract
//  PC_src         out  1       resolved taken (combinational)
//  mispredict     out  1       ex_valid & ~ex_stall & (PC_src != ex_pred_taken) (combinational)
//  err            out  1       illegal code while ex_valid (combinational)
//  err_sticky     out  1       latched err; cleared only by reset
//  br_count       out  STAT_W  conditional branches resolved
//  mispred_count  out  STAT_W  mispredicts
// BEHAVIOUR
//  Condition codes (LT = SF^OF):
//    0000 none:0   0001 EQ:ZF   0010 NE:~ZF   0011 LT:LT   0100 GE:~LT
//    0101 ULT:CF   0110 UGE:~CF  0111 always:1  1000 LE:LT|ZF  1001 GT:~LT&~ZF
//    1010-1111 illegal: PC_src=0, err=ex_valid. PC_src is 0 whenever ex_valid=0.
//  Lookup:
//    - f_pred_taken = table[f_pc idx][1].
//    - Code 0111 carries ex_pred_taken=1 from decode; a mismatch still flags mispredict.
//  Update: occurs at the clock edge when upd = ex_valid & ~ex_stall & code in {0001..0110,1000,1001}.
//    - Taken: counter +1, saturating at 11. Not taken: counter -1, saturating at 00.
//    - Codes 0000, 0111 and illegal codes never train the table.
//  Same-index lookup and update in one cycle: lookup returns the pre-update value (read-old).
//    The new value is visible the next cycle.
//  Stats:
//    - br_count +1 on each upd.
//    - mispred_count +1 on each mispredict, including code 0111.
//    - Both saturate at all-ones and never wrap.
//  err_sticky sets on the first cycle err=1 with ex_stall=0 and holds until reset.
//  Reset, asynchronous, any time including mid-stall:
//    - Every counter goes to 01 (weakly not taken).
//    - br_count=0, mispred_count=0, err_sticky=0.
//    - Combinational outputs follow their inputs.
//  Latency: resolution 0 cycles (combinational); training visible 1 cycle after the update edge.
// STRUCTURE
//  Package branch_pkg:
//    - condition-code localparams (BR_NONE..BR_GT)
//    - counter encodings (SNT=00, WNT=01, WT=10, ST=11)
//    - function cond_eval(code, ZF, CF, SF, OF)
//  Sub-module branch_hist_table (params DEPTH, PC_W):
//    - counter array with async reset
//    - one combinational read port
//    - one synchronous saturating-update port
//  Top level holds cond_eval, mispredict/err logic and the stats counters.
// TESTING
//  1. Reset, then f_pc=any -> f_pred_taken=0; stats=0; err_sticky=0.
//  2. ex_pc=0x0010, code 0001, ZF=1, three upd cycles
//     -> PC_src=1 each cycle; counter 01->10->11->11; f_pc=0x0010 then predicts 1.
//  3. Code 0011 with SF=1,OF=1 -> PC_src=0; code 0101 with CF=1 -> PC_src=1;
//     code 1001 with ZF=0,SF=0,OF=0 -> PC_src=1.
//  4. ex_branch=1100, ex_valid=1 -> err=1, PC_src=0, err_sticky=1 next cycle;
//     the same stimulus with ex_stall=1 leaves err_sticky=0 and changes no state.
//  5. f_pc=ex_pc=0x0020 with update taken in the same cycle
//     -> f_pred_taken=0 (old value, 01) that cycle, 1 the next.
//  6. With STAT_W=4: 20 mispredicts -> mispred_count sticks at 0xF;
//     assert rst_n mid-stream -> all counters 01 and stats 0 asynchronously.

Source files
------------

// File: rtl/branch_predict_resolve_pkg.sv
// Shared condition codes, counter encodings and branch condition helpers.
package branch_pkg;

  localparam logic [3:0] BR_NONE = 4'b0000;
  localparam logic [3:0] BR_EQ   = 4'b0001;
  localparam logic [3:0] BR_NE   = 4'b0010;
  localparam logic [3:0] BR_LT   = 4'b0011;
  localparam logic [3:0] BR_GE   = 4'b0100;
  localparam logic [3:0] BR_ULT  = 4'b0101;
  localparam logic [3:0] BR_UGE  = 4'b0110;
  localparam logic [3:0] BR_AL   = 4'b0111;
  localparam logic [3:0] BR_LE   = 4'b1000;
  localparam logic [3:0] BR_GT   = 4'b1001;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  // Resolve a condition code against ALU flags; illegal codes resolve not taken.
  function automatic logic cond_eval(logic [3:0] code, logic zf, logic cf, logic sf, logic of);
    logic lt;
    lt = sf ^ of;
    case (code)
      BR_NONE: cond_eval = 1'b0;
      BR_EQ:   cond_eval = zf;
      BR_NE:   cond_eval = ~zf;
      BR_LT:   cond_eval = lt;
      BR_GE:   cond_eval = ~lt;
      BR_ULT:  cond_eval = cf;
      BR_UGE:  cond_eval = ~cf;
      BR_AL:   cond_eval = 1'b1;
      BR_LE:   cond_eval = lt | zf;
      BR_GT:   cond_eval = ~lt & ~zf;
      default: cond_eval = 1'b0;
    endcase
  endfunction

  function automatic logic is_illegal(logic [3:0] code);
    is_illegal = (code > BR_GT);
  endfunction

  // Only genuinely conditional branches train the predictor.
  function automatic logic is_cond(logic [3:0] code);
    is_cond = (code != BR_NONE) && (code != BR_AL) && !is_illegal(code);
  endfunction

endpackage

// File: rtl/branch_predict_resolve_if.sv
// Fetch lookup and execute resolve signals between the pipeline and the branch block.
interface branch_predict_resolve_if #(parameter int PC_W = 16) ();
  logic [PC_W-1:0] f_pc;
  logic            f_pred_taken;
  logic            ex_valid;
  logic            ex_stall;
  logic [PC_W-1:0] ex_pc;
  logic [3:0]      ex_branch;
  logic            ex_pred_taken;
  logic            ZF, CF, SF, OF;
  logic            PC_src;
  logic            mispredict;
  logic            err;

  modport master (
    output f_pc, ex_valid, ex_stall, ex_pc, ex_branch, ex_pred_taken, ZF, CF, SF, OF,
    input  f_pred_taken, PC_src, mispredict, err
  );
  modport slave (
    input  f_pc, ex_valid, ex_stall, ex_pc, ex_branch, ex_pred_taken, ZF, CF, SF, OF,
    output f_pred_taken, PC_src, mispredict, err
  );
endinterface

// File: rtl/branch_predict_resolve_hist_table.sv
// Direct-mapped table of 2-bit saturating counters; comb read, registered update.
module branch_hist_table #(
  parameter int DEPTH = 16,
  parameter int PC_W  = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [PC_W-1:0] rd_pc,
  output logic            rd_taken,
  input  logic            upd_en,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken
);
  import branch_pkg::*;

  localparam int IDX_W = $clog2(DEPTH);

  logic [DEPTH-1:0][1:0] ctr;
  logic [IDX_W-1:0]      rd_idx, upd_idx;

  // Halfword-aligned PCs: bit 0 never selects an entry.
  assign rd_idx   = rd_pc[IDX_W:1];
  assign upd_idx  = upd_pc[IDX_W:1];
  assign rd_taken = ctr[rd_idx][1];

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    // Per-entry saturating counter; a read in the same cycle sees the old value.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ctr[i] <= WNT;
      end else if (upd_en && (upd_idx == IDX_W'(i))) begin
        if (upd_taken && ctr[i] != ST)        ctr[i] <= ctr[i] + 2'd1;
        else if (!upd_taken && ctr[i] != SNT) ctr[i] <= ctr[i] - 2'd1;
      end
    end
  end

endmodule

// File: rtl/branch_predict_resolve.sv
// Execute-stage branch resolve, mispredict/err detection, predictor training and stats.
module branch_predict_resolve #(
  parameter int PC_W      = 16,
  parameter int BHT_DEPTH = 16,
  parameter int STAT_W    = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  branch_predict_resolve_if.slave bus,
  output logic                   err_sticky,
  output logic [STAT_W-1:0]      br_count,
  output logic [STAT_W-1:0]      mispred_count
);
  import branch_pkg::*;

  logic live, upd;

  assign live           = bus.ex_valid & ~bus.ex_stall;
  assign upd            = live & is_cond(bus.ex_branch);
  assign bus.PC_src     = bus.ex_valid & cond_eval(bus.ex_branch, bus.ZF, bus.CF, bus.SF, bus.OF);
  assign bus.mispredict = live & (bus.PC_src != bus.ex_pred_taken);
  assign bus.err        = bus.ex_valid & is_illegal(bus.ex_branch);

  branch_hist_table #(.DEPTH(BHT_DEPTH), .PC_W(PC_W)) u_bht (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_pc     (bus.f_pc),
    .rd_taken  (bus.f_pred_taken),
    .upd_en    (upd),
    .upd_pc    (bus.ex_pc),
    .upd_taken (bus.PC_src)
  );

  // Saturating perf counters and sticky error flag; a stall freezes them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_count      <= '0;
      mispred_count <= '0;
      err_sticky    <= 1'b0;
    end else begin
      if (upd && br_count != '1)                  br_count      <= br_count + 1'b1;
      if (bus.mispredict && mispred_count != '1)  mispred_count <= mispred_count + 1'b1;
      if (bus.err && !bus.ex_stall)               err_sticky    <= 1'b1;
    end
  end

endmodule
